// File: rtl/multi_stream_profiler_pkg.sv
// multi_stream_profiler_pkg: shared types and helpers for the multi-stream profiler.
// Optional feature macro used by the profiler files: STREAM_PROFILER_LATENCY_EN.
package multi_stream_profiler_pkg;

  typedef logic [63:0] data64_t;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STREAM = 2'd1,
    IDLE   = 2'd2
  } profiler_state_t;

  typedef struct packed {
    data64_t handshakes;
    data64_t starved;
    data64_t stalled;
    data64_t idle;
    data64_t streams;
  } profiler_counters_t;

  // Increment that sticks at max_value instead of wrapping.
  function automatic data64_t sat_inc(input data64_t value, input data64_t max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

  // Largest value representable in a counter of the given width.
  function automatic data64_t cnt_max(input int bits);
    return (bits >= 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
  endfunction

endpackage

// File: rtl/multi_stream_profiler_channel.sv
// stream_profiler_channel: FSM and saturating counters for one observed stream.
// STREAM_PROFILER_LATENCY_EN adds a first_beat_latency counter and port.
module stream_profiler_channel
  import multi_stream_profiler_pkg::*;
#(
  parameter int CNT_BITS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic               ready,
  input  logic               last,
  input  logic               stop,
  input  logic               clear,
  output logic               active,
  output profiler_counters_t counters
`ifdef STREAM_PROFILER_LATENCY_EN
  ,
  output data64_t            first_beat_latency
`endif
);

  localparam data64_t CNT_MAX = cnt_max(CNT_BITS);

  profiler_state_t    state_q;
  profiler_state_t    state_d;
  profiler_counters_t counters_q;
  profiler_counters_t counters_d;
  profiler_counters_t base;
  logic               handshake;
  logic               last_beat;

  assign handshake = valid & ready;
  assign last_beat = handshake & last;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT;
    else        state_q <= state_d;
  end

  // Next state: a last handshake ends the stream, any other valid keeps it open.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT: begin
        if (valid) state_d = last_beat ? (stop ? WAIT : IDLE) : STREAM;
      end
      STREAM, IDLE: begin
        if (last_beat)  state_d = stop ? WAIT : IDLE;
        else if (valid) state_d = STREAM;
      end
      default: state_d = WAIT;
    endcase
    if (clear) state_d = WAIT;
  end

  // Counter update: a valid in WAIT restarts from zero, then exactly one cycle class is counted.
  always_comb begin
    base       = (state_q == WAIT) ? '0 : counters_q;
    counters_d = counters_q;
    if (valid || (state_q != WAIT)) begin
      counters_d = base;
      if (handshake)              counters_d.handshakes = sat_inc(base.handshakes, CNT_MAX);
      else if (valid)             counters_d.stalled    = sat_inc(base.stalled, CNT_MAX);
      else if (state_q == IDLE)   counters_d.idle       = sat_inc(base.idle, CNT_MAX);
      else                        counters_d.starved    = sat_inc(base.starved, CNT_MAX);
      if (last_beat)              counters_d.streams    = sat_inc(base.streams, CNT_MAX);
    end
    if (clear) counters_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) counters_q <= '0;
    else        counters_q <= counters_d;
  end

  assign active   = (state_q != WAIT);
  assign counters = counters_q;

`ifdef STREAM_PROFILER_LATENCY_EN
  logic    armed_q;
  data64_t latency_q;

  // Count empty WAIT cycles after arming; the first valid freezes the count until re-armed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      armed_q   <= 1'b1;
      latency_q <= '0;
    end else if (armed_q && (state_q == WAIT)) begin
      if (valid) armed_q   <= 1'b0;
      else       latency_q <= sat_inc(latency_q, CNT_MAX);
    end
  end

  assign first_beat_latency = latency_q;
`endif

endmodule

// File: rtl/multi_stream_profiler.sv
// multi_stream_profiler: N_STREAMS profiler channels behind one registered readout mux.
// STREAM_PROFILER_LATENCY_EN adds the first_beat_latency readout port.
module multi_stream_profiler
  import multi_stream_profiler_pkg::*;
#(
  parameter  int N_STREAMS = 4,
  parameter  int CNT_BITS  = 64,
  localparam int SEL_W     = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_STREAMS-1:0] valid,
  input  logic [N_STREAMS-1:0] ready,
  input  logic [N_STREAMS-1:0] last,
  input  logic [N_STREAMS-1:0] stop,
  input  logic [N_STREAMS-1:0] clear,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [N_STREAMS-1:0] active,
  output data64_t              handshakes_cycles,
  output data64_t              starved_cycles,
  output data64_t              stalled_cycles,
  output data64_t              idle_cycles,
  output data64_t              stream_count
`ifdef STREAM_PROFILER_LATENCY_EN
  ,
  output data64_t              first_beat_latency
`endif
);

  profiler_counters_t ch_cnt [N_STREAMS];
  profiler_counters_t rd_q;
  logic               sel_ok;

  assign sel_ok = (32'(rd_sel) < N_STREAMS);

`ifdef STREAM_PROFILER_LATENCY_EN
  data64_t ch_lat [N_STREAMS];
  data64_t lat_q;
`endif

  for (genvar g = 0; g < N_STREAMS; g++) begin : g_chan
    stream_profiler_channel #(
      .CNT_BITS(CNT_BITS)
    ) u_chan (
      .clk               (clk),
      .rst_n             (rst_n),
      .valid             (valid[g]),
      .ready             (ready[g]),
      .last              (last[g]),
      .stop              (stop[g]),
      .clear             (clear[g]),
      .active            (active[g]),
      .counters          (ch_cnt[g])
`ifdef STREAM_PROFILER_LATENCY_EN
      ,
      .first_beat_latency(ch_lat[g])
`endif
    );
  end

  // Registered readout of the selected channel; out-of-range selects read zeros.
  always_ff @(posedge clk) begin
    if (!rst_n)      rd_q <= '0;
    else if (sel_ok) rd_q <= ch_cnt[rd_sel];
    else             rd_q <= '0;
  end

  assign handshakes_cycles = rd_q.handshakes;
  assign starved_cycles    = rd_q.starved;
  assign stalled_cycles    = rd_q.stalled;
  assign idle_cycles       = rd_q.idle;
  assign stream_count      = rd_q.streams;

`ifdef STREAM_PROFILER_LATENCY_EN
  // Latency readout shares the select and timing of the main counters.
  always_ff @(posedge clk) begin
    if (!rst_n)      lat_q <= '0;
    else if (sel_ok) lat_q <= ch_lat[rd_sel];
    else             lat_q <= '0;
  end

  assign first_beat_latency = lat_q;
`endif

endmodule

// File: tb/tb_multi_stream_profiler.sv
// tb_multi_stream_profiler: table-driven, directed and randomized checks of multi_stream_profiler.
// Build with STREAM_PROFILER_LATENCY_EN defined to also exercise first_beat_latency.
module tb_multi_stream_profiler;
  import multi_stream_profiler_pkg::*;

  localparam int              NS  = 4;
  localparam int              CB  = 16;
  localparam longint unsigned SAT = 65535;

  typedef struct {
    longint unsigned h, st, sl, id, sc;
  } tb_cnt_t;

  typedef struct {
    bit v, r, l, s;
    longint unsigned eh, est, esl, eid, esc;
    bit eact;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] valid = '0, ready = '0, last = '0, stop = '0, clear = '0;
  logic [1:0]    rd_sel = '0;
  logic [NS-1:0] active;
  data64_t       handshakes_cycles, starved_cycles, stalled_cycles, idle_cycles, stream_count;
`ifdef STREAM_PROFILER_LATENCY_EN
  data64_t       first_beat_latency;
`endif

  int checks = 0;
  int errors = 0;

  tb_cnt_t       m [NS];
  bit            m_wait [NS];
  bit            m_gap [NS];
  tb_cnt_t       exp_rd;
  logic [NS-1:0] exp_act;

  multi_stream_profiler #(
    .N_STREAMS(NS),
    .CNT_BITS (CB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid            (valid),
    .ready            (ready),
    .last             (last),
    .stop             (stop),
    .clear            (clear),
    .rd_sel           (rd_sel),
    .active           (active),
    .handshakes_cycles(handshakes_cycles),
    .starved_cycles   (starved_cycles),
    .stalled_cycles   (stalled_cycles),
    .idle_cycles      (idle_cycles),
    .stream_count     (stream_count)
`ifdef STREAM_PROFILER_LATENCY_EN
    ,
    .first_beat_latency(first_beat_latency)
`endif
  );

  always #5 clk = ~clk;

  // Time limit so the bench can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint unsigned bump(input longint unsigned x);
    return (x < SAT) ? x + 1 : x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m[i]      = '{default: 0};
      m_wait[i] = 1'b1;
      m_gap[i]  = 1'b0;
    end
  endfunction

  // Reference behaviour: waiting channels restart on valid, then each observed cycle falls in one class.
  function automatic void model_step(input int ch, input bit v, input bit r, input bit l,
                                     input bit s, input bit c);
    if (c) begin
      m[ch] = '{default: 0};
      m_wait[ch] = 1'b1;
      m_gap[ch]  = 1'b0;
      return;
    end
    if (m_wait[ch] && !v) return;
    if (m_wait[ch]) begin
      m[ch] = '{default: 0};
      m_wait[ch] = 1'b0;
      m_gap[ch]  = 1'b0;
    end
    if (v && r)        m[ch].h  = bump(m[ch].h);
    else if (v)        m[ch].sl = bump(m[ch].sl);
    else if (m_gap[ch]) m[ch].id = bump(m[ch].id);
    else               m[ch].st = bump(m[ch].st);
    if (v && r && l) begin
      m[ch].sc = bump(m[ch].sc);
      if (s) m_wait[ch] = 1'b1;
      else   m_gap[ch]  = 1'b1;
    end else if (v) begin
      m_gap[ch] = 1'b0;
    end
  endfunction

  task automatic compare(input string name, input string field, input logic [63:0] got,
                         input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got=%0d exp=%0d", name, field, got, exp);
    end
  endtask

  // Drive one cycle; exp_rd/exp_act end up holding what the DUT should show after this edge.
  task automatic applyStimulus(input logic [NS-1:0] v, input logic [NS-1:0] r,
                               input logic [NS-1:0] l, input logic [NS-1:0] s,
                               input logic [NS-1:0] c, input logic [1:0] sel);
    valid = v; ready = r; last = l; stop = s; clear = c; rd_sel = sel;
    @(posedge clk);
    if (!rst_n) begin
      exp_rd = '{default: 0};
      model_reset();
    end else begin
      exp_rd = m[sel];
      for (int i = 0; i < NS; i++) model_step(i, v[i], r[i], l[i], s[i], c[i]);
    end
    for (int i = 0; i < NS; i++) exp_act[i] = !m_wait[i];
    #1;
  endtask

  task automatic checkOutput(input string name, input tb_cnt_t e, input logic [NS-1:0] e_act);
    compare(name, "handshakes", handshakes_cycles, e.h);
    compare(name, "starved", starved_cycles, e.st);
    compare(name, "stalled", stalled_cycles, e.sl);
    compare(name, "idle", idle_cycles, e.id);
    compare(name, "streams", stream_count, e.sc);
    compare(name, "active", 64'(active), 64'(e_act));
  endtask

  // Single-channel convenience wrapper.
  task automatic drive1(input int ch, input bit v, input bit r, input bit l, input bit s,
                        input bit c, input logic [1:0] sel);
    logic [NS-1:0] one;
    one = NS'(1) << ch;
    applyStimulus(v ? one : '0, r ? one : '0, l ? one : '0, s ? one : '0, c ? one : '0, sel);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, '0, 2'd0);
    applyStimulus('0, '0, '0, '0, '0, 2'd0);
    rst_n = 1'b1;
  endtask

  function automatic tb_cnt_t mk(input longint unsigned h, input longint unsigned st,
                                 input longint unsigned sl, input longint unsigned id,
                                 input longint unsigned sc);
    tb_cnt_t t;
    t.h = h; t.st = st; t.sl = sl; t.id = id; t.sc = sc;
    return t;
  endfunction

  initial begin
    vec_t tbl [8];
    logic [NS-1:0] rv, rr, rl, rs, rc;

    // Readout lags the event by two edges: each row expects the counters after the previous row.
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 0, 0, 0, 2, 1, 0, 0, 0, 1};
    tbl[4] = '{1, 1, 0, 0, 2, 1, 1, 0, 0, 1};
    tbl[5] = '{1, 1, 1, 1, 3, 1, 1, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 4, 1, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 4, 1, 1, 0, 1, 0};

    $display("[TB] start");
    doReset();
    checkOutput("reset", mk(0, 0, 0, 0, 0), '0);

    // Stream 0 pattern V,V,!V,stall,V,V+last+stop.
    for (int i = 0; i < 8; i++) begin
      drive1(0, tbl[i].v, tbl[i].r, tbl[i].l, tbl[i].s, 1'b0, 2'd0);
      checkOutput($sformatf("tbl%0d", i),
                  mk(tbl[i].eh, tbl[i].est, tbl[i].esl, tbl[i].eid, tbl[i].esc),
                  {3'b000, tbl[i].eact});
    end

    // Channel 1: two 3-beat streams with a 5-cycle gap, stop on the second last.
    doReset();
    drive1(1, 1, 1, 0, 0, 0, 2'd1);
    drive1(1, 1, 1, 0, 0, 0, 2'd1);
    drive1(1, 1, 1, 1, 0, 0, 2'd1);
    for (int i = 0; i < 5; i++) drive1(1, 0, 0, 0, 0, 0, 2'd1);
    drive1(1, 1, 1, 0, 0, 0, 2'd1);
    drive1(1, 1, 1, 0, 0, 0, 2'd1);
    drive1(1, 1, 1, 1, 1, 0, 2'd1);
    drive1(1, 0, 0, 0, 0, 0, 2'd1);
    checkOutput("ch1_two_streams", mk(6, 0, 0, 5, 2), '0);
    drive1(1, 0, 0, 0, 0, 0, 2'd0);
    checkOutput("ch0_zero", mk(0, 0, 0, 0, 0), '0);
    drive1(1, 0, 0, 0, 0, 0, 2'd1);
    checkOutput("rdsel_back", mk(6, 0, 0, 5, 2), '0);

    // Channel 2: single-beat stream then idle cycles.
    doReset();
    drive1(2, 1, 1, 1, 0, 0, 2'd2);
    for (int i = 0; i < 4; i++) drive1(2, 0, 0, 0, 0, 0, 2'd2);
    checkOutput("single_beat_idle", mk(1, 0, 0, 3, 1), 4'b0100);

    // Clear on channel 2 during a handshake; channel 3 keeps counting.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 4'b1100, '0, '0, '0, 2'd2);
    applyStimulus(4'b1100, 4'b1100, '0, '0, 4'b0100, 2'd2);
    checkOutput("clear_edge", mk(3, 0, 0, 0, 0), 4'b1000);
    applyStimulus('0, '0, '0, '0, '0, 2'd2);
    checkOutput("clear_ch2", mk(0, 0, 0, 0, 0), 4'b1000);
    applyStimulus('0, '0, '0, '0, '0, 2'd3);
    checkOutput("clear_ch3_kept", mk(4, 1, 0, 0, 0), 4'b1000);

    // Saturation of stalled on channel 3.
    doReset();
    for (int i = 0; i < 70001; i++) drive1(3, 1, 0, 0, 0, 0, 2'd3);
    checkOutput("sat_stalled", mk(0, 0, SAT, 0, 0), 4'b1000);
    drive1(3, 1, 0, 0, 0, 0, 2'd3);
    checkOutput("sat_hold", mk(0, 0, SAT, 0, 0), 4'b1000);

`ifdef STREAM_PROFILER_LATENCY_EN
    // First-beat latency: clear, 7 empty cycles, then a beat.
    doReset();
    drive1(0, 0, 0, 0, 0, 1, 2'd0);
    for (int i = 0; i < 7; i++) drive1(0, 0, 0, 0, 0, 0, 2'd0);
    drive1(0, 1, 1, 0, 0, 0, 2'd0);
    drive1(0, 0, 0, 0, 0, 0, 2'd0);
    drive1(0, 0, 0, 0, 0, 0, 2'd0);
    compare("latency", "first_beat_latency", first_beat_latency, 64'd7);
`endif

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        rv[i] = ($urandom_range(0, 9) < 7);
        rr[i] = ($urandom_range(0, 9) < 6);
        rl[i] = ($urandom_range(0, 9) < 3);
        rs[i] = ($urandom_range(0, 1) == 1);
        rc[i] = ($urandom_range(0, 99) < 2);
      end
      applyStimulus(rv, rr, rl, rs, rc, 2'($urandom_range(0, 3)));
      checkOutput($sformatf("rand%0d", n), exp_rd, exp_act);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_stream_profiler.md
# multi_stream_profiler

Parametrised, multi-channel successor to the single-stream profiler. It observes N_STREAMS independent valid/ready/last interfaces, without driving them. For each stream it counts handshakes, starved, stalled and idle cycles, plus completed streams, in saturating counters of configurable width. A registered channel-select port reads out one channel's counters, so a single CSR window can expose every monitored stream in a kernel.

## Interface
- N_STREAMS, 4, number of monitored streams (1..64)
- CNT_BITS, 64, counter width (16..64); counters zero-extend to data64_t on output
- clk  in  1  clock
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- valid  in  N_STREAMS  per-stream valid
- ready  in  N_STREAMS  per-stream ready
- last  in  N_STREAMS  per-stream last
- stop  in  N_STREAMS  per-stream stop; only honoured on a last handshake
- clear  in  N_STREAMS  per-stream synchronous clear/re-arm pulse
- rd_sel  in  $clog2(N_STREAMS) (min 1)  channel to read out
- active  out  N_STREAMS  channel state != WAIT
- handshakes_cycles, starved_cycles, stalled_cycles, idle_cycles, stream_count  out  data64_t each  counters of channel rd_sel

## Operation
- Per-channel FSM: WAIT (armed, counters held), STREAM (inside a stream), IDLE (between a last and the next valid).
- WAIT:
  - valid=0 → hold.
  - valid=1 → zero all counters of that channel, then apply this cycle's event as below.
  - Next state:
    - valid&!ready → STREAM.
    - handshake & !last → STREAM.
    - handshake & last & !stop → IDLE.
    - handshake & last & stop → WAIT.
- STREAM:
  - valid&ready → handshakes+1.
  - valid&!ready → stalled+1.
  - !valid → starved+1.
  - Handshake with last → stream_count+1, then go to WAIT if stop, else IDLE.
- IDLE:
  - !valid → idle+1.
  - valid → counted exactly as in STREAM, and the state becomes STREAM unless it is a last handshake, which follows the STREAM rule.
- Exactly one of handshake/stalled/starved/idle increments per non-WAIT cycle.
- stop without a last handshake: ignored.
- Counters saturate at 2^CNT_BITS−1 and never wrap; the other counters keep counting.
- clear[i]:
  - Forces channel i to WAIT and zeroes its counters next cycle.
  - Overrides any same-cycle event on that channel.
  - Other channels are unaffected.
- After stop, counters hold until the next valid in WAIT (or until clear), so software can read them.

## Timing
- Reset: every FSM in WAIT, all counters 0, active=0, all outputs 0.
- Reset mid-stream discards state. The first valid after reset starts a new measurement.
- Counter updates are visible internally one cycle after the observed cycle.
- Readout latency:
  - Outputs are registered and reflect channel rd_sel, sampled one cycle earlier, with counters as of that sampling edge.
  - Total latency from event to output is 2 cycles.
- active is registered and rises the cycle after the first valid.
- rd_sel ≥ N_STREAMS reads zeros.

## Configuration
- STREAM_PROFILER_LATENCY_EN.
- Defined:
  - Each channel adds a first_beat_latency counter (CNT_BITS, saturating).
  - It zeroes on reset/clear and increments every WAIT cycle with valid=0 after arming.
  - It freezes on the first valid, and is not zeroed by the valid that leaves WAIT.
  - Output port first_beat_latency (data64_t) is added to the readout mux with the same 2-cycle latency.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package (the one holding data64_t):
  - profiler_state_t enum {WAIT, STREAM, IDLE}.
  - profiler_counters_t struct (handshakes, starved, stalled, idle, streams).
  - Saturating-increment function.
- Sub-module stream_profiler_channel: one FSM plus counters, generated N_STREAMS times.
- Top level holds only the generate loop and the registered readout mux.

## Test plan
- Stream 0 handshakes 4 beats with pattern V,V,¬V,V(stall),V,V+last+stop → handshakes=4, starved=1, stalled=1, idle=0, stream_count=1, state WAIT. The stall cycle is not a handshake, so the six cycles are four handshakes plus one starved plus one stalled cycle.
- Channel 1: two 3-beat streams separated by 5 idle cycles, stop on the second last → handshakes=6, idle=5, stream_count=2. Channel 0 stays all zeros.
- Single-beat stream in WAIT with last&!stop, then 3 idle cycles → state IDLE, idle=3, handshakes=1.
- CNT_BITS=16, valid=1, ready=0 for 70000 cycles → stalled=65535 and holds.
- clear[2] pulsed mid-stream on the same cycle as a handshake → channel 2 counters=0, state WAIT, no increment. Channel 3 counts continue unchanged.
- With STREAM_PROFILER_LATENCY_EN: clear, 7 cycles with valid=0, then a stream → first_beat_latency=7. rd_sel change is reflected on the outputs 1 cycle later.
